// File: rtl/counter_pkg.sv
// Shared definitions for the load/run counter scheduler.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int              DEF_WIDTH    = 4;
  localparam logic [3:0]      DEF_TERMINAL = 4'hF;
  localparam int              WD_WIDTH     = 5;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from the index after ptr.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int               cand;
  logic [IDX_W-1:0] sel;

  // First requester found after the pointer, wrapping, wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = 0;
    sel   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      sel = IDX_W'(cand);
      if (!valid && req[sel]) begin
        valid      = 1'b1;
        idx        = sel;
        grant[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_load_sched.sv
// Schedules requesters onto one shared loadable counter, one job at a time.
module counter_load_sched
  import counter_pkg::*;
#(
  parameter  int               NUM_REQ  = 4,
  parameter  int               WIDTH    = DEF_WIDTH,
  parameter  logic [WIDTH-1:0] TERMINAL = WIDTH'(DEF_TERMINAL),
  parameter  int               WD_LIMIT = 18,
  localparam int               IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_val,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              done,
  output logic                            err,
  output logic                            busy,
  output logic                            cnt_load,
  output logic [WIDTH-1:0]                cnt_data_in,
  input  logic [WIDTH-1:0]                cnt_data_out
);

  localparam logic [WD_WIDTH-1:0] WD_LIM = WD_WIDTH'(WD_LIMIT);

  state_t               state, state_next;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     owner;
  logic [NUM_REQ-1:0]   owner_oh;
  logic [WIDTH-1:0]     val_reg;
  logic [WD_WIDTH-1:0]  wd;
  logic                 err_flag;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_valid;
  logic                 terminal;
  logic                 abort;
  logic                 wd_expire;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Next-state decision; terminal count beats abort, abort beats watchdog.
  always_comb begin
    state_next = state;
    terminal   = (cnt_data_out == TERMINAL);
    abort      = !req[owner];
    wd_expire  = ((wd + 1'b1) == WD_LIM) && !terminal && !abort;
    case (state)
      IDLE: if (arb_valid) state_next = LOAD;
      LOAD: state_next = RUN;
      RUN: begin
        if (terminal)       state_next = DONE;
        else if (abort)     state_next = IDLE;
        else if (wd_expire) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, ownership, watchdog and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= IDX_W'(NUM_REQ - 1);
      owner    <= '0;
      owner_oh <= '0;
      val_reg  <= '0;
      wd       <= '0;
      err_flag <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            owner    <= arb_idx;
            owner_oh <= arb_grant;
            val_reg  <= req_val[arb_idx];
          end
        end
        LOAD: begin
          wd       <= '0;
          err_flag <= 1'b0;
        end
        RUN: begin
          wd <= wd + 1'b1;
          if (wd_expire) err_flag <= 1'b1;
          if (!terminal && abort) ptr <= owner;
        end
        DONE: ptr <= owner;
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign gnt         = busy ? owner_oh : '0;
  assign done        = (state == DONE) ? owner_oh : '0;
  assign err         = (state == DONE) && err_flag;
  assign cnt_load    = (state == LOAD);
  assign cnt_data_in = val_reg;

endmodule

// File: tb/tb_counter_load_sched.sv
// Scoreboard bench for counter_load_sched with a behavioural counter.
module tb_counter_load_sched;

  logic             clk;
  logic             rst;
  logic [3:0]       req;
  logic [3:0][3:0]  req_val;
  logic [3:0]       gnt;
  logic [3:0]       done;
  logic             err;
  logic             busy;
  logic             cnt_load;
  logic [3:0]       cnt_data_in;
  logic [3:0]       cnt_data_out;

  logic [3:0]       cnt_q;
  logic             stuck;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] data;
    int         gap;
  } load_exp_t;

  typedef struct {
    logic [3:0] done;
    logic       err;
    int         lat;
  } done_exp_t;

  load_exp_t load_q[$];
  done_exp_t done_q[$];
  load_exp_t le;
  done_exp_t de;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  int last_load_cycle = -1;

  counter_load_sched #(
    .NUM_REQ  (4),
    .WIDTH    (4),
    .TERMINAL (4'hF),
    .WD_LIMIT (18)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_val      (req_val),
    .gnt          (gnt),
    .done         (done),
    .err          (err),
    .busy         (busy),
    .cnt_load     (cnt_load),
    .cnt_data_in  (cnt_data_in),
    .cnt_data_out (cnt_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External counter: loads on strobe, otherwise increments mod 16.
  always_ff @(posedge clk) begin
    if (cnt_load) cnt_q <= cnt_data_in;
    else          cnt_q <= cnt_q + 4'd1;
  end
  assign cnt_data_out = stuck ? 4'h3 : cnt_q;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic apply_stimulus(input logic [3:0] new_req);
    req = new_req;
  endtask

  task automatic wait_load(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cnt_load && n < budget);
    if (!cnt_load) check_output("wait_load_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int idx, input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[idx] && n < budget);
    if (!done[idx]) check_output($sformatf("wait_done%0d_timeout", idx), 32'd0, 32'd1);
  endtask

  // Monitor: pops expectations whenever a load strobe or done pulse appears.
  always @(negedge clk) begin
    cycle++;
    check_output("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
    check_output("done_onehot", 32'($countones(done) <= 1), 32'd1);
    if (cnt_load) begin
      if (load_q.size() == 0) begin
        check_output("unexpected_load_gnt", 32'(gnt), 32'd0);
      end else begin
        le = load_q.pop_front();
        check_output("load_gnt", 32'(gnt), 32'(le.gnt));
        check_output("load_data", 32'(cnt_data_in), 32'(le.data));
        if (le.gap >= 0) check_output("load_gap", 32'(cycle - last_load_cycle), 32'(le.gap));
      end
      last_load_cycle = cycle;
    end
    if (done != 4'd0) begin
      if (done_q.size() == 0) begin
        check_output("unexpected_done", 32'(done), 32'd0);
      end else begin
        de = done_q.pop_front();
        check_output("done_vec", 32'(done), 32'(de.done));
        check_output("done_err", 32'(err), 32'(de.err));
        check_output("done_latency", 32'(cycle - last_load_cycle), 32'(de.lat));
        check_output("done_gnt", 32'(gnt), 32'(de.done));
      end
    end else begin
      check_output("err_without_done", 32'(err), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    rst     = 1'b0;
    stuck   = 1'b0;
    req     = 4'd0;
    req_val = '0;

    // Reset for two edges, then idle with no requests.
    repeat (2) begin
      @(negedge clk);
      check_output("rst_gnt", 32'(gnt), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_load", 32'(cnt_load), 32'd0);
      check_output("rst_data_in", 32'(cnt_data_in), 32'd0);
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_output("idle_gnt", 32'(gnt), 32'd0);
      check_output("idle_busy", 32'(busy), 32'd0);
      check_output("idle_load", 32'(cnt_load), 32'd0);
    end

    // Single job from 0xC; req_val changed after grant must be ignored.
    load_q.push_back('{4'b0001, 4'hC, -1});
    done_q.push_back('{4'b0001, 1'b0, 5});
    req_val[0] = 4'hC;
    apply_stimulus(4'b0001);
    wait_load(10);
    req_val[0] = 4'h2;
    wait_done(0, 20);
    apply_stimulus(4'b0000);

    // Fresh reset, then all four request with start 0xF.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    load_q.push_back('{4'b0001, 4'hF, -1});
    for (int i = 1; i < 5; i++) load_q.push_back('{4'(1 << (i % 4)), 4'hF, 4});
    for (int i = 0; i < 5; i++) done_q.push_back('{4'(1 << (i % 4)), 1'b0, 2});
    req_val = {4'hF, 4'hF, 4'hF, 4'hF};
    apply_stimulus(4'b1111);
    wait_done(0, 20);
    wait_done(1, 20);
    wait_done(2, 20);
    wait_done(3, 20);
    wait_done(0, 20);
    apply_stimulus(4'b0000);

    // Requester 2 from 0x0, abandoned on its third RUN cycle.
    load_q.push_back('{4'b0100, 4'h0, -1});
    req_val[2] = 4'h0;
    apply_stimulus(4'b0100);
    wait_load(10);
    repeat (3) @(negedge clk);
    load_q.push_back('{4'b1000, 4'hE, -1});
    done_q.push_back('{4'b1000, 1'b0, 3});
    load_q.push_back('{4'b0001, 4'hF, -1});
    done_q.push_back('{4'b0001, 1'b0, 2});
    req_val[3] = 4'hE;
    req_val[0] = 4'hF;
    apply_stimulus(4'b1001);
    @(negedge clk);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_gnt", 32'(gnt), 32'd0);
    wait_done(3, 20);
    apply_stimulus(4'b0001);
    wait_done(0, 20);
    apply_stimulus(4'b0000);

    // Stuck counter: watchdog ends the job after 18 RUN cycles.
    stuck = 1'b1;
    load_q.push_back('{4'b0010, 4'h5, -1});
    done_q.push_back('{4'b0010, 1'b1, 19});
    req_val[1] = 4'h5;
    apply_stimulus(4'b0010);
    wait_done(1, 40);
    apply_stimulus(4'b0000);
    stuck = 1'b0;

    // Reset in the middle of a run, then requester 0 wins over 2.
    load_q.push_back('{4'b0100, 4'h0, -1});
    req_val[2] = 4'h0;
    apply_stimulus(4'b0100);
    wait_load(10);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    apply_stimulus(4'b0000);
    @(negedge clk);
    check_output("midrst_gnt", 32'(gnt), 32'd0);
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_data_in", 32'(cnt_data_in), 32'd0);
    rst = 1'b1;
    load_q.push_back('{4'b0001, 4'hE, -1});
    done_q.push_back('{4'b0001, 1'b0, 3});
    req_val[0] = 4'hE;
    apply_stimulus(4'b0101);
    wait_done(0, 20);
    apply_stimulus(4'b0000);

    repeat (5) @(negedge clk);
    check_output("load_q_empty", 32'(load_q.size()), 32'd0);
    check_output("done_q_empty", 32'(done_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
